mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux datapath. It grants exclusive mux access to one requester at a time, drives `S` to route that requester's data, and registers the selected data with a valid flag. It sits directly in front of the 2:1 mux and is the only block allowed to drive its select.

## Interface
Parameters:
- `WIDTH`, 1: data width of each requester input and of `data_out`.
- `MAX_HOLD`, 4: maximum consecutive granted cycles while the other side is requesting. Range 1..15. Used only with `MUX_ARB_HOLD_LIMIT_EN`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req0`  input  1  requester 0 wants the mux; level-held while it wants access.
- `req1`  input  1  requester 1 wants the mux.
- `I0`  input  WIDTH  requester 0 data.
- `I1`  input  WIDTH  requester 1 data.
- `gnt0`  output  1  registered grant to requester 0.
- `gnt1`  output  1  registered grant to requester 1.
- `S`  output  1  mux select; 0 = `I0`, 1 = `I1`; registered.
- `data_out`  output  WIDTH  registered selected data.
- `data_valid`  output  1  `data_out` holds data captured under a grant.

## Operation
- States: `IDLE` (gnt0=0, gnt1=0), `G0` (gnt0=1, S=0), `G1` (gnt1=1, S=1). `gnt0`/`gnt1` are one-hot or both 0, never both 1.
- Round-robin pointer `last`: the index of the most recent grant. Reset value is 1, so the first contested grant goes to requester 0.
- From `IDLE`:
  - Only `req0` → `G0`; only `req1` → `G1`.
  - Both requests → the side opposite `last`.
  - Neither → stay in `IDLE`.
- From `G0` (`G1` is symmetric):
  - `req0` still high → stay in `G0`, subject to the hold limit under `MUX_ARB_HOLD_LIMIT_EN`.
  - `req0` low and `req1` high → go directly to `G1` with no `IDLE` bubble.
  - Both low → `IDLE`.
- `last` updates on every entry into `G0` or `G1`.
- `S` holds its last value in `IDLE`; its reset value is 0.
- Data capture: on each rising edge where `gnt0` (or `gnt1`) is high, `data_out` ← `I0` (or `I1`) and `data_valid` ← 1. On other edges `data_valid` ← 0 and `data_out` holds its value.
- Hold counter: 4 bits. It clears on every grant change or on entry to `IDLE`, increments each cycle a grant is held, and saturates at 15.

## Timing
- Reset (asynchronous, immediate, including mid-grant) forces:
  - `gnt0`=0, `gnt1`=0, `S`=0, `data_out`=0, `data_valid`=0
  - state `IDLE`, `last`=1, counter 0.
- After `rst_n` deasserts, the first grant is possible on the first rising edge.
- Request to grant: one cycle. A request sampled high at edge n produces a grant visible after edge n.
- Release: a requester that drops its request at edge n loses its grant after edge n.
- Grant to data: one cycle. The data present during a granted cycle appears on `data_out` with `data_valid`=1 after the following edge.
- Both requests arriving on the same edge from `IDLE` are resolved by `last`.
- A request that drops and re-asserts in the same cycle is seen only as a level; no edge detection is performed.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined:
  - In `G0`, if `req1`=1 and the counter equals `MAX_HOLD`, the next state is `G1` even though `req0`=1 (symmetric for `G1`).
  - With the other side idle, the holder keeps the grant indefinitely.
- Not defined: the hold counter and `MAX_HOLD` are not used, and a holder keeps the grant for as long as its request stays high.

## Test plan
- Reset mid-grant: in `G1`, pull `rst_n` low between edges → `gnt1`=0, `S`=0, `data_valid`=0 immediately. After release, asserting both requests → `gnt0` first.
- Single requester: `req0`=1 for 3 cycles with `I0`=1 → `gnt0`=1 for 3 cycles. `data_out`=1 with `data_valid`=1 for 3 cycles, each lagging the grant by one cycle.
- Contention from `IDLE` with `last`=0: both requests on one edge → `gnt1`=1, `S`=1.
- Back-to-back handoff: in `G0` with `req1` high, drop `req0` → `gnt1`=1 on the next edge with no idle cycle, and `data_valid` stays continuously 1.
- With `MUX_ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=4: hold `req0` and `req1` high → grants alternate 0,0,0,0,0,1,1,1,1,1,0… (`MAX_HOLD`+1 cycles each).
- Without `MUX_ARB_HOLD_LIMIT_EN`, same stimulus → `gnt0` stays high for the entire run.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Bundle of the requester-side handshake and shared-mux signals for mux_arbiter.
// master: the requesters and the mux consumer. slave: the arbiter itself.
interface mux_arbiter_if #(
    parameter int WIDTH = 1
) ();
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             gnt0;
    logic             gnt1;
    logic             S;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;

    modport master (
        output req0, req1, I0, I1,
        input  gnt0, gnt1, S, data_out, data_valid
    );

    modport slave (
        input  req0, req1, I0, I1,
        output gnt0, gnt1, S, data_out, data_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter that owns the select of the shared 2:1 mux
// and registers the selected data with a valid flag.
// Optional feature: define MUX_ARB_HOLD_LIMIT_EN to force a handoff after a
// holder has kept the grant MAX_HOLD+1 cycles while the other side waits.
//
// state | meaning
// IDLE  | no grant, S holds its last value
// G0    | requester 0 granted, S=0
// G1    | requester 1 granted, S=1
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input logic         clk,
    input logic         rst_n,
    mux_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             s_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             hold_exp;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("mux_arbiter: MAX_HOLD must be in 1..15");
    end

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [3:0] hold_cnt;

    assign hold_exp = (hold_cnt == 4'(MAX_HOLD));

    // Consecutive-hold counter: clears on any grant change or idle, saturates at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 4'd0;
        end else if (state_nxt != IDLE && state_nxt == state) begin
            if (hold_cnt != 4'd15) hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= 4'd0;
        end
    end
`else
    assign hold_exp = 1'b0;
`endif

    // Next-state: round-robin from IDLE, direct handoff between grants.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) state_nxt = last ? G0 : G1;
                else if (bus.req0)        state_nxt = G0;
                else if (bus.req1)        state_nxt = G1;
                else                      state_nxt = IDLE;
            end
            G0: begin
                if (bus.req0 && !(bus.req1 && hold_exp)) state_nxt = G0;
                else if (bus.req1)                       state_nxt = G1;
                else                                     state_nxt = IDLE;
            end
            G1: begin
                if (bus.req1 && !(bus.req0 && hold_exp)) state_nxt = G1;
                else if (bus.req0)                       state_nxt = G0;
                else                                     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Round-robin pointer and mux select follow the grant; both hold through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
            s_q  <= 1'b0;
        end else if (state_nxt == G0) begin
            last <= 1'b0;
            s_q  <= 1'b0;
        end else if (state_nxt == G1) begin
            last <= 1'b1;
            s_q  <= 1'b1;
        end
    end

    // Capture the granted requester's data one cycle behind the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == G0) || (state == G1);
            if (state == G0)      data_q <= bus.I0;
            else if (state == G1) data_q <= bus.I1;
        end
    end

    assign bus.gnt0       = (state == G0);
    assign bus.gnt1       = (state == G1);
    assign bus.S          = s_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: the driver updates an ownership model and
// queues the expected post-edge outputs; the monitor pops and compares.
module tb_mux_arbiter;
    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic             g0;
        logic             g1;
        logic             s;
        logic             dv;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // model: owner -1 = nobody, else requester index
    int               owner;
    int               m_last;
    int               m_hold;
    logic             m_s;
    logic             m_dv;
    logic [WIDTH-1:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        owner  = -1;
        m_last = 1;
        m_hold = 0;
        m_s    = 1'b0;
        m_dv   = 1'b0;
        m_data = '0;
    endtask

    task automatic step(input logic r0, input logic r1,
                        input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1);
        bit rq[2];
        int nxt;
        exp_t e;
        @(negedge clk);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.I0   = i0;
        bus.I1   = i1;
        rq[0] = r0;
        rq[1] = r1;
        if (owner >= 0) begin
            m_data = (owner == 1) ? i1 : i0;
            m_dv   = 1'b1;
        end else begin
            m_dv = 1'b0;
        end
        if (owner < 0) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            if (rq[owner] && !(LIMIT && rq[1-owner] && m_hold == MAX_HOLD)) nxt = owner;
            else if (rq[1-owner]) nxt = 1 - owner;
            else                  nxt = -1;
        end
        if (nxt >= 0 && nxt == owner) m_hold = (m_hold < 15) ? m_hold + 1 : 15;
        else                          m_hold = 0;
        if (nxt >= 0) begin
            m_last = nxt;
            m_s    = (nxt == 1);
        end
        owner = nxt;
        e.g0 = (owner == 0);
        e.g1 = (owner == 1);
        e.s  = m_s;
        e.dv = m_dv;
        e.d  = m_data;
        q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: compare every post-edge output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("gnt0", 32'(bus.gnt0), 32'(e.g0));
                    chk("gnt1", 32'(bus.gnt1), 32'(e.g1));
                    chk("S", 32'(bus.S), 32'(e.s));
                    chk("data_valid", 32'(bus.data_valid), 32'(e.dv));
                    chk("data_out", 32'(bus.data_out), 32'(e.d));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.I0   = '0;
        bus.I1   = '0;
        model_reset();
        #12;
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester, three cycles
        repeat (3) step(1'b1, 1'b0, 4'h1, 4'h0);
        repeat (2) step(1'b0, 1'b0, 4'h0, 4'h0);
        // contention from idle with last=0 -> requester 1
        repeat (2) step(1'b1, 1'b1, 4'h5, 4'h9);
        repeat (2) step(1'b0, 1'b0, 4'h0, 4'h0);
        // sustained contention: hold-limit alternation or permanent holder
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 4'(i), 4'(15 - i));
        // back-to-back handoff by dropping the current holder's request
        step(owner == 0, owner != 0, 4'h3, 4'hc);
        repeat (3) step(owner == 1, owner != 1, 4'ha, 4'h6);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        // randomized traffic, biased toward long holds
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom), WIDTH'($urandom));
        repeat (2) step(1'b0, 1'b0, 4'h0, 4'h0);

        // asynchronous reset in the middle of a G1 grant
        repeat (2) step(1'b0, 1'b1, 4'h3, 4'h7);
        @(posedge clk);
        #3;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        chk("midrst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("midrst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("midrst_S", 32'(bus.S), 32'd0);
        chk("midrst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("midrst_data_out", 32'(bus.data_out), 32'd0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1, 4'h2, 4'he);
        step(1'b0, 1'b0, 4'h0, 4'h0);

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
